sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Round-robin arbiter sharing one single-port 16-bit SPRAM between the SPI write path (`spi_in`) and up to four `icnd2110_out` read requesters. It replaces the fixed two-reader sharing in the top level so all LED outputs can be enabled. Each request is latched, writes always win, and readers are served round-robin with a per-port completion strobe. The SPRAM primitive sits outside the block; this block drives its address, data and write-enable.

## Interface
Parameters:
- `ADDRESS_BUS_WIDTH`, default 14: word address width.
- `READ_PORTS`, default 4: number of read requesters, 1..4.

Ports:
- `clk`  in  1  system clock (24 MHz HFOSC).
- `rst`  in  1  reset; synchronous, active-high.
- `write_address`  in  AW  word address of the SPI write.
- `write_data`  in  16  SPI write data.
- `write_strobe`  in  1  single-cycle write request.
- `read_address`  in  READ_PORTS*AW  per-port read address; port i occupies bits [i*AW +: AW].
- `read_strobe`  in  READ_PORTS  per-port single-cycle read request.
- `read_data`  out  16  data for the most recently completed read; shared by all ports.
- `read_finished_strobe`  out  READ_PORTS  one-cycle pulse; `read_data` is valid for that port.
- `sram_address`  out  AW  SPRAM address.
- `sram_data_in`  out  16  SPRAM write data.
- `sram_write_enable`  out  1  SPRAM write enable.
- `sram_data_out`  in  16  SPRAM read data, valid one cycle after the address edge.
- `write_overrun`  out  1  sticky flag: a write was lost.
- `state`  out  3  debug state encoding.

## Operation
- Request capture: `write_strobe` loads the write-holding register (address and data) and sets `wr_pending`. `read_strobe[i]` captures `read_address[i]` and sets `rd_pending[i]`.
- `write_strobe` while `wr_pending` is already set: the new write overwrites the held one and `write_overrun` sets. Only `rst` clears it.
- `read_strobe[i]` while `rd_pending[i]` is set or port i is in flight: ignored, and the captured address is unchanged. Requesters wait for their finished strobe before issuing again.
- A strobe arriving on the same edge that its pending bit clears is captured as a new request.
- State machine (encoding on `state`):
  - IDLE=0: if `wr_pending`, go to WRITE. Else if any `rd_pending`, pick the first pending port starting at `rr_ptr` and wrapping modulo READ_PORTS; register grant and address; go to READ.
  - WRITE=1: `sram_write_enable`=1 with the held address and data. Clear `wr_pending`. Go to IDLE.
  - READ=2: `sram_address` = granted address, `sram_write_enable`=0. Clear `rd_pending[grant]`. Set `rr_ptr` = grant+1 (wrapping). Go to READ_DONE.
  - READ_DONE=3: register `sram_data_out` into `read_data` and pulse `read_finished_strobe[grant]` on the exit edge. Go to IDLE.
- Writes have strict priority. Writes are guaranteed spaced ≥4 cycles apart, so readers cannot starve.
- Simultaneous write and read strobes: both are latched. The write is served first.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_ptr`=0, all pending bits 0.
- `rst` mid-operation: any in-flight read is dropped with no finished strobe. Any pending write is discarded. `sram_write_enable` is 0 on the next cycle.
- Uncontended read: strobe in cycle 0 → READ in cycle 2 → `read_finished_strobe` high in cycle 4, with `read_data` valid the same cycle and held until the next read completes.
- Uncontended write: strobe in cycle 0 → `sram_write_enable` high for exactly one cycle, cycle 2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- `read_finished_strobe` is one-hot and at most one bit is set per cycle.
- `sram_address`, `sram_data_in` and `sram_write_enable` are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds: state encoding constants (IDLE/WRITE/READ/READ_DONE), data width 16, and the default `ADDRESS_BUS_WIDTH`.
- One sub-module, `rr_pick`: combinational; inputs are the pending mask and `rr_ptr`; outputs are `grant_valid` and a `grant_index`. It is also reusable for a future output-start scheduler.

## Test plan
- Single read: preload mem[0x0010]=0xBEEF, strobe port 2 at address 0x0010 → `read_finished_strobe`=4'b0100 four cycles later, `read_data`=0xBEEF.
- Write then readback: write 0x1234 to 0x2A00, then port 0 reads 0x2A00 → `sram_write_enable` pulses once, and the read returns 0x1234.
- Round-robin fairness: ports 0–3 all strobe together, at addresses holding 0xA0..0xA3 → finished strobes arrive in order 0,1,2,3, three cycles apart, with matching data. The next burst starts from the port following the last one served.
- Write priority and overrun: a write and four reads in the same cycle → WRITE is served first. A second write_strobe one cycle later → `write_overrun`=1, and only the second write reaches the SRAM.
- Reset mid-read: assert `rst` during READ_DONE → no finished strobe, all outputs 0, and a new read after reset completes normally.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SPRAM arbiter: FSM encoding, data width and
// default address width.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_DONE = 3'd3
  } state_t;

  localparam int DATA_WIDTH                = 16;
  localparam int DEFAULT_ADDRESS_BUS_WIDTH = 14;

  // Next round-robin position after idx, wrapping at the port count.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int ports);
    return (int'(idx) == ports - 1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of the pending mask,
// scanning upward from the pointer and wrapping modulo PORTS.
module rr_pick
  import sram_arbiter_pkg::*;
#(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0] i_pending,
  input  logic [1:0]       i_ptr,
  output logic             o_grant_valid,
  output logic [1:0]       o_grant_index
);

  // Scan from farthest to nearest so the port closest to the pointer wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_index = 2'd0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      o_grant_valid = o_grant_valid | i_pending[(int'(i_ptr) + k) % PORTS];
      o_grant_index = i_pending[(int'(i_ptr) + k) % PORTS] ?
                      2'((int'(i_ptr) + k) % PORTS) : o_grant_index;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SPRAM between the SPI write path (strict priority)
// and up to four round-robin readers with per-port completion strobes.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = DEFAULT_ADDRESS_BUS_WIDTH,
  parameter int READ_PORTS        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0]           write_address,
  input  logic [DATA_WIDTH-1:0]                  write_data,
  input  logic                                   write_strobe,
  input  logic [READ_PORTS*ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic [READ_PORTS-1:0]                  read_strobe,
  output logic [DATA_WIDTH-1:0]                  read_data,
  output logic [READ_PORTS-1:0]                  read_finished_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0]           sram_address,
  output logic [DATA_WIDTH-1:0]                  sram_data_in,
  output logic                                   sram_write_enable,
  input  logic [DATA_WIDTH-1:0]                  sram_data_out,
  output logic                                   write_overrun,
  output logic [2:0]                             state
);

  localparam int AW = ADDRESS_BUS_WIDTH;

  state_t                  r_state, w_next_state;
  logic                    r_wr_pending, r_overrun;
  logic [AW-1:0]           r_wr_addr, w_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data, w_wr_data;
  logic [READ_PORTS-1:0]   r_rd_pending, w_rd_take, w_rd_clear;
  logic [AW-1:0]           r_rd_addr [READ_PORTS];
  logic [1:0]              r_rr_ptr, r_grant, w_grant_index;
  logic                    w_grant_valid, w_wr_clear;
  logic [AW-1:0]           r_sram_addr;
  logic [DATA_WIDTH-1:0]   r_sram_din, r_read_data;
  logic                    r_sram_we;
  logic [READ_PORTS-1:0]   r_finished;

  rr_pick #(.PORTS(READ_PORTS)) u_rr_pick (
    .i_pending     (r_rd_pending),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_index (w_grant_index)
  );

  // A write strobing on the same edge that WRITE is entered replaces the held one.
  assign w_wr_addr = write_strobe ? write_address : r_wr_addr;
  assign w_wr_data = write_strobe ? write_data    : r_wr_data;

  // Which requests are accepted this edge and which pending bits retire.
  always_comb begin
    w_rd_take  = '0;
    w_rd_clear = '0;
    w_wr_clear = (r_state == ST_WRITE);
    for (int i = 0; i < READ_PORTS; i++) begin
      w_rd_clear[i] = (r_state == ST_READ) && (r_grant == 2'(i));
      w_rd_take[i]  = read_strobe[i]
                      && !(r_rd_pending[i] && !w_rd_clear[i])
                      && !((r_state == ST_READ_DONE) && (r_grant == 2'(i)));
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_wr_pending) begin
          w_next_state = ST_WRITE;
        end else if (w_grant_valid) begin
          w_next_state = ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WRITE:     w_next_state = ST_IDLE;
      ST_READ:      w_next_state = ST_READ_DONE;
      ST_READ_DONE: w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request holding registers and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_pending <= 1'b0;
      r_overrun    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_pending <= '0;
      for (int i = 0; i < READ_PORTS; i++) begin
        r_rd_addr[i] <= '0;
      end
    end else begin
      if (write_strobe) begin
        r_wr_pending <= 1'b1;
        r_wr_addr    <= write_address;
        r_wr_data    <= write_data;
        if (r_wr_pending && !w_wr_clear) begin
          r_overrun <= 1'b1;
        end
      end else if (w_wr_clear) begin
        r_wr_pending <= 1'b0;
      end
      for (int i = 0; i < READ_PORTS; i++) begin
        if (w_rd_take[i]) begin
          r_rd_pending[i] <= 1'b1;
          r_rd_addr[i]    <= read_address[i*AW +: AW];
        end else if (w_rd_clear[i]) begin
          r_rd_pending[i] <= 1'b0;
        end
      end
    end
  end

  // SPRAM drive, grant tracking and read completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_sram_we   <= 1'b0;
      r_read_data <= '0;
      r_finished  <= '0;
      r_rr_ptr    <= 2'd0;
      r_grant     <= 2'd0;
    end else begin
      r_sram_we  <= 1'b0;
      r_finished <= '0;
      case (r_state)
        ST_IDLE: begin
          if (r_wr_pending) begin
            r_sram_we   <= 1'b1;
            r_sram_addr <= w_wr_addr;
            r_sram_din  <= w_wr_data;
          end else if (w_grant_valid) begin
            r_grant     <= w_grant_index;
            r_sram_addr <= r_rd_addr[w_grant_index];
          end
        end
        ST_READ:      r_rr_ptr <= wrap_inc(r_grant, READ_PORTS);
        ST_READ_DONE: begin
          r_read_data <= sram_data_out;
          r_finished  <= READ_PORTS'(1'b1) << r_grant;
        end
        default: begin
        end
      endcase
    end
  end

  assign read_data            = r_read_data;
  assign read_finished_strobe = r_finished;
  assign sram_address         = r_sram_addr;
  assign sram_data_in         = r_sram_din;
  assign sram_write_enable    = r_sram_we;
  assign write_overrun        = r_overrun;
  assign state                = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SPRAM
// (registered read, one cycle after the address edge).
module tb_sram_arbiter;

  localparam int AW = 14;
  localparam int RP = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     write_address;
  logic [15:0]       write_data;
  logic              write_strobe;
  logic [RP*AW-1:0]  read_address;
  logic [RP-1:0]     read_strobe;
  logic [15:0]       read_data;
  logic [RP-1:0]     read_finished_strobe;
  logic [AW-1:0]     sram_address;
  logic [15:0]       sram_data_in;
  logic              sram_write_enable;
  logic [15:0]       sram_data_out;
  logic              write_overrun;
  logic [2:0]        state;

  logic [15:0]       mem [0:(1<<AW)-1];
  logic              pl_en;
  logic [AW-1:0]     pl_addr;
  logic [15:0]       pl_data;

  int checks = 0;
  int errors = 0;

  int            we_cnt;
  logic [AW-1:0] we_addr;
  logic [15:0]   we_data;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDRESS_BUS_WIDTH(AW), .READ_PORTS(RP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .write_address        (write_address),
    .write_data           (write_data),
    .write_strobe         (write_strobe),
    .read_address         (read_address),
    .read_strobe          (read_strobe),
    .read_data            (read_data),
    .read_finished_strobe (read_finished_strobe),
    .sram_address         (sram_address),
    .sram_data_in         (sram_data_in),
    .sram_write_enable    (sram_write_enable),
    .sram_data_out        (sram_data_out),
    .write_overrun        (write_overrun),
    .state                (state)
  );

  // SPRAM model; pl_* lets the bench preload contents while the DUT is idle.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (sram_write_enable) mem[sram_address] <= sram_data_in;
    sram_data_out <= mem[sram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic set_rd_addr(input int port, input logic [AW-1:0] a);
    read_address[port*AW +: AW] = a;
  endtask

  // Uncontended read issued in the current cycle (cycle 0).
  task automatic do_read(input int port, input logic [AW-1:0] a, input logic [15:0] exp);
    read_strobe = 4'b0001 << port;
    step();
    read_strobe = '0;
    check("rd_c1_state", state, 3'd0);
    step();
    check("rd_c2_state", state, 3'd2);
    check("rd_c2_addr", sram_address, a);
    check("rd_c2_we", sram_write_enable, 1'b0);
    step();
    check("rd_c3_fin", read_finished_strobe, 4'b0000);
    step();
    check("rd_c4_fin", read_finished_strobe, 4'b0001 << port);
    check("rd_c4_data", read_data, exp);
  endtask

  // Steps cycles from..to; the k-th completion lands at cycle first+3k on
  // port order[2k+:2] with data 0xA0+port. Also records SRAM write pulses.
  task automatic watch(input int from, input int to, input int first, input int n,
                       input logic [7:0] order);
    logic [3:0] exp_fin;
    int         p;
    we_cnt = 0;
    for (int c = from; c <= to; c++) begin
      step();
      write_strobe = 1'b0;
      read_strobe  = '0;
      if (sram_write_enable) begin
        we_cnt++;
        we_addr = sram_address;
        we_data = sram_data_in;
      end
      exp_fin = 4'b0000;
      p = 0;
      if (c >= first && ((c - first) % 3) == 0 && ((c - first) / 3) < n) begin
        p = int'(order[2*((c - first) / 3) +: 2]);
        exp_fin = 4'b0001 << p;
      end
      check($sformatf("fin_c%0d", c), read_finished_strobe, exp_fin);
      if (exp_fin != 4'b0000) check($sformatf("data_c%0d", c), read_data, 16'h00A0 + p);
    end
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    write_address = '0; write_data = '0; write_strobe = 1'b0;
    read_address = '0; read_strobe = '0;
    we_cnt = 0; we_addr = '0; we_data = '0;
    step(); step();
    check("rst_state", state, 3'd0);
    check("rst_we", sram_write_enable, 1'b0);
    check("rst_addr", sram_address, 14'd0);
    check("rst_din", sram_data_in, 16'd0);
    check("rst_rdata", read_data, 16'd0);
    check("rst_fin", read_finished_strobe, 4'b0000);
    check("rst_ovr", write_overrun, 1'b0);
    rst = 1'b0;

    preload(14'h0010, 16'hBEEF);
    for (int i = 0; i < RP; i++) begin
      preload(14'h0100 + 14'(i), 16'h00A0 + 16'(i));
      set_rd_addr(i, 14'h0100 + 14'(i));
    end
    preload(14'h0300, 16'hDEAD);

    // Single read on port 2.
    set_rd_addr(2, 14'h0010);
    do_read(2, 14'h0010, 16'hBEEF);
    step();
    check("single_fin_off", read_finished_strobe, 4'b0000);
    check("single_hold", read_data, 16'hBEEF);
    set_rd_addr(2, 14'h0102);

    // Write then readback through port 0.
    write_address = 14'h2A00; write_data = 16'h1234; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    check("wr_c1_we", sram_write_enable, 1'b0);
    step();
    check("wr_c2_we", sram_write_enable, 1'b1);
    check("wr_c2_addr", sram_address, 14'h2A00);
    check("wr_c2_din", sram_data_in, 16'h1234);
    check("wr_c2_state", state, 3'd1);
    step();
    check("wr_c3_we", sram_write_enable, 1'b0);
    set_rd_addr(0, 14'h2A00);
    do_read(0, 14'h2A00, 16'h1234);
    set_rd_addr(0, 14'h0100);
    check("no_overrun", write_overrun, 1'b0);

    // Port 3 served last, so the next burst starts at port 0.
    do_read(3, 14'h0103, 16'h00A3);
    read_strobe = 4'hF;
    watch(1, 13, 4, 4, 8'hE4);
    check("burst1_we", we_cnt, 0);

    // Port 1 served last, so the next burst runs 2,3,0,1.
    do_read(1, 14'h0101, 16'h00A1);
    read_strobe = 4'hF;
    watch(1, 13, 4, 4, 8'h4E);

    // Write priority with overrun: second write one cycle later wins.
    write_address = 14'h0300; write_data = 16'h1111; write_strobe = 1'b1;
    read_strobe = 4'hF;
    step();
    read_strobe = '0;
    write_address = 14'h0301; write_data = 16'h2222; write_strobe = 1'b1;
    watch(2, 15, 6, 4, 8'h4E);
    check("prio_we_cnt", we_cnt, 1);
    check("prio_we_addr", we_addr, 14'h0301);
    check("prio_we_data", we_data, 16'h2222);
    check("prio_overrun", write_overrun, 1'b1);
    check("prio_mem_old", mem[14'h0300], 16'hDEAD);
    check("prio_mem_new", mem[14'h0301], 16'h2222);

    // Reset asserted while port 0's read is in READ_DONE.
    step();
    read_strobe = 4'b0001;
    step();
    read_strobe = '0;
    step();
    step();
    check("mid_state_rd_done", state, 3'd3);
    rst = 1'b1;
    step();
    check("mid_fin", read_finished_strobe, 4'b0000);
    check("mid_state", state, 3'd0);
    check("mid_we", sram_write_enable, 1'b0);
    check("mid_addr", sram_address, 14'd0);
    check("mid_rdata", read_data, 16'd0);
    check("mid_ovr", write_overrun, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_fin", read_finished_strobe, 4'b0000);
    do_read(1, 14'h0101, 16'h00A1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
